// File: rtl/apb_master_nslv.sv
// APB master bridge: decodes the core address into one of NUM_SLAVES PSEL lines and runs IDLE/SETUP/ACCESS,
// reporting decode errors, PSLVERR and PREADY timeouts back to the core through ready/error.
module apb_master_nslv #(
  parameter int                NUM_SLAVES    = 4,
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 32'h1000_0000,
  parameter int                SLV_SIZE_LOG2 = 12,
  parameter int                TIMEOUT       = 255
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         transfer,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ready,
  output logic                         error,
  output logic [ADDR_W-1:0]            PADDR,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic                         PENABLE,
  output logic [NUM_SLAVES-1:0]        PSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  sel_idx;
  logic              dec_err;
  logic [CNT_W-1:0]  cnt;
  logic              capture;

  logic [ADDR_W-1:0] addr_off;
  logic [ADDR_W-1:0] addr_index;
  logic              req_mapped;
  logic [IDX_W-1:0]  req_idx;

  logic              sel_pready;
  logic              sel_pslverr;
  logic [DATA_W-1:0] sel_prdata;

  // Address decode on the raw request; the result is registered at capture.
  assign addr_off   = addr - BASE_ADDR;
  assign addr_index = addr_off >> SLV_SIZE_LOG2;
  assign req_mapped = (addr >= BASE_ADDR) && (addr_index < ADDR_W'(NUM_SLAVES));
  assign req_idx    = addr_index[IDX_W-1:0];

  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_pready  = PREADY[i];
        sel_pslverr = PSLVERR[i];
        sel_prdata  = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    PSEL = '0;
    if (state != ST_IDLE && !dec_err) PSEL[sel_idx] = 1'b1;
  end

  assign PENABLE = (state == ST_ACCESS);

  // Completion precedence: decode error, then slave PREADY, then watchdog expiry.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    error     = 1'b0;
    rdata     = '0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (transfer) begin
          capture   = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (dec_err) begin
          ready = 1'b1;
          error = 1'b1;
        end else if (sel_pready) begin
          ready = 1'b1;
          error = sel_pslverr;
          if (!PWRITE && !sel_pslverr) rdata = sel_prdata;
        end else if (TO_EN && cnt == CNT_LAST) begin
          ready = 1'b1;
          error = 1'b1;
        end
        if (ready) begin
          capture   = transfer;
          state_nxt = transfer ? ST_SETUP : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      sel_idx <= '0;
      dec_err <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        PADDR   <= addr;
        PWRITE  <= write;
        PWDATA  <= wdata;
        sel_idx <= req_mapped ? req_idx : '0;
        dec_err <= !req_mapped;
      end
      // Counts elapsed ACCESS cycles without completion; saturates rather than wrapping.
      if (state == ST_ACCESS && !ready) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Self-checking bench for apb_master_nslv: directed test-plan cases plus randomized transactions
// checked against a transaction-level model (decode map, latency, error and read data).
module tb_apb_master_nslv;

  localparam int          NS   = 4;
  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic                 PCLK = 1'b0;
  logic                 PRESET;
  logic                 transfer;
  logic                 write;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        wdata;
  logic [DW-1:0]        rdata;
  logic                 ready;
  logic                 error;
  logic [AW-1:0]        PADDR;
  logic                 PWRITE;
  logic [DW-1:0]        PWDATA;
  logic                 PENABLE;
  logic [NS-1:0]        PSEL;
  logic [NS*DW-1:0]     PRDATA;
  logic [NS-1:0]        PREADY;
  logic [NS-1:0]        PSLVERR;

  int compared   = 0;
  int mismatched = 0;

  always #5 PCLK = ~PCLK;

  apb_master_nslv #(
    .NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE),
    .SLV_SIZE_LOG2(12), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .error(error), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Transaction-level reference: memory map, latency in cycles after the request edge, error, read data.
  function automatic void model(input logic [31:0] a, input logic wr, input int waits,
                                input logic slverr, input logic [31:0] rd,
                                output logic [NS-1:0] psel, output int lat,
                                output logic err, output logic [31:0] rdat);
    logic [31:0] slot;
    if (a < BASE || (a - BASE) / 32'd4096 >= NS) begin
      psel = '0; lat = 2; err = 1'b1; rdat = '0;
    end else begin
      slot = (a - BASE) / 32'd4096;
      psel = NS'(1) << slot;
      if (waits < TO) begin
        lat  = 2 + waits;
        err  = slverr;
        rdat = (!wr && !slverr) ? rd : 32'h0;
      end else begin
        lat = 1 + TO; err = 1'b1; rdat = '0;
      end
    end
  endfunction

  task automatic drive_slaves(input int k, input logic [NS-1:0] psel, input int waits,
                              input logic slverr, input logic [31:0] rd);
    for (int i = 0; i < NS; i++) begin
      if (psel[i]) begin
        PREADY[i]  = (k > waits);
        PSLVERR[i] = slverr;
        PRDATA[i*DW +: DW] = rd;
      end else begin
        PREADY[i]  = 1'($urandom);
        PSLVERR[i] = 1'($urandom);
        PRDATA[i*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    transfer = 1'b1; addr = a; write = wr; wdata = wd;
  endtask

  // Runs one transfer whose request is already on the bus; with keep=1 the next request is held
  // on the bus so it is captured in this transfer's completion cycle.
  task automatic run_txn(input string name, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         input int waits, input logic slverr, input logic [31:0] rd,
                         input bit keep, input logic [31:0] na, input logic nwr, input logic [31:0] nwd);
    logic [NS-1:0] e_psel;
    int            e_lat;
    logic          e_err;
    logic [31:0]   e_rd;
    bit            done;
    model(a, wr, waits, slverr, rd, e_psel, e_lat, e_err, e_rd);
    @(posedge PCLK); #1;
    if (keep) begin
      addr = na; write = nwr; wdata = nwd;
    end else begin
      transfer = 1'b0; addr = $urandom; write = 1'($urandom); wdata = $urandom;
    end
    drive_slaves(0, e_psel, waits, slverr, rd);
    @(negedge PCLK);
    compared++;
    if ({PSEL, PENABLE, ready, error, rdata, PADDR, PWRITE, PWDATA} !==
        {e_psel, 1'b0, 1'b0, 1'b0, 32'h0, a, wr, wd}) begin
      mismatched++;
      $display("[TB] FAIL %s setup: got psel=%b en=%b rdy=%b err=%b rd=%h pa=%h pw=%b wd=%h want psel=%b en=0 rdy=0 err=0 rd=0 pa=%h pw=%b wd=%h",
               name, PSEL, PENABLE, ready, error, rdata, PADDR, PWRITE, PWDATA, e_psel, a, wr, wd);
    end
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(posedge PCLK); #1;
      drive_slaves(k, e_psel, waits, slverr, rd);
      @(negedge PCLK);
      compared++;
      if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA} !== {e_psel, 1'b1, a, wr, wd}) begin
        mismatched++;
        $display("[TB] FAIL %s access%0d bus: got psel=%b en=%b pa=%h pw=%b wd=%h want psel=%b en=1 pa=%h pw=%b wd=%h",
                 name, k, PSEL, PENABLE, PADDR, PWRITE, PWDATA, e_psel, a, wr, wd);
      end
      if (ready === 1'b1) begin
        done = 1'b1;
        compared++;
        if (k + 1 != e_lat) begin
          mismatched++;
          $display("[TB] FAIL %s latency: got %0d want %0d", name, k + 1, e_lat);
        end
        compared++;
        if ({error, rdata} !== {e_err, e_rd}) begin
          mismatched++;
          $display("[TB] FAIL %s result: got err=%b rd=%h want err=%b rd=%h", name, error, rdata, e_err, e_rd);
        end
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s no ready within 40 cycles: got 0 want ready at %0d", name, e_lat);
    end
    if (!keep) begin
      @(posedge PCLK); #1;
      drive_slaves(0, '0, 0, 1'b0, 32'h0);
      @(negedge PCLK);
      compared++;
      if ({PSEL, PENABLE, ready, error, rdata} !== '0) begin
        mismatched++;
        $display("[TB] FAIL %s idle after: got psel=%b en=%b rdy=%b err=%b rd=%h want all 0",
                 name, PSEL, PENABLE, ready, error, rdata);
      end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    drive_slaves(0, '0, 0, 1'b0, 32'h0);
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    compared++;
    if ({PSEL, PENABLE, ready, error, rdata, PADDR, PWRITE, PWDATA} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset state: got psel=%b en=%b rdy=%b err=%b rd=%h pa=%h pw=%b wd=%h want all 0",
               PSEL, PENABLE, ready, error, rdata, PADDR, PWRITE, PWDATA);
    end
  endtask

  task automatic test_zero_wait_read();
    issue(32'h1000_1004, 1'b0, 32'h1234_5678);
    run_txn("zero_wait_read", 32'h1000_1004, 1'b0, 32'h1234_5678, 0, 1'b0, 32'hDEAD_BEEF, 0, 0, 0, 0);
  endtask

  task automatic test_write_wait();
    issue(32'h1000_0010, 1'b1, 32'h0000_00A5);
    run_txn("write_3wait", 32'h1000_0010, 1'b1, 32'h0000_00A5, 3, 1'b0, 32'hCAFE_F00D, 0, 0, 0, 0);
  endtask

  task automatic test_decode_error();
    issue(32'h1000_4000, 1'b0, 32'h0);
    run_txn("unmapped_high", 32'h1000_4000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_1111, 0, 0, 0, 0);
    issue(32'h0FFF_FFFC, 1'b1, 32'h5555_AAAA);
    run_txn("unmapped_low", 32'h0FFF_FFFC, 1'b1, 32'h5555_AAAA, 0, 1'b0, 32'h2222_2222, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    issue(32'h1000_3020, 1'b0, 32'h0);
    run_txn("timeout", 32'h1000_3020, 1'b0, 32'h0, 30, 1'b0, 32'h3333_3333, 0, 0, 0, 0);
    issue(32'h1000_2000, 1'b0, 32'h0);
    run_txn("ready_at_last", 32'h1000_2000, 1'b0, 32'h0, TO - 1, 1'b0, 32'h7777_0001, 0, 0, 0, 0);
  endtask

  task automatic test_slverr();
    issue(32'h1000_2008, 1'b0, 32'h0);
    run_txn("pslverr", 32'h1000_2008, 1'b0, 32'h0, 1, 1'b1, 32'h4444_4444, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    issue(32'h1000_3000, 1'b0, 32'h0);
    run_txn("b2b_read", 32'h1000_3000, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D,
            1, 32'h1000_1008, 1'b1, 32'h6666_7777);
    run_txn("b2b_write", 32'h1000_1008, 1'b1, 32'h6666_7777, 2, 1'b0, 32'h0,
            1, 32'h1000_0100, 1'b0, 32'h0);
    @(posedge PCLK); #1;
    transfer = 1'b0;
    drive_slaves(0, 4'b0001, 100, 1'b0, 32'h0);
    @(posedge PCLK); #1;
    drive_slaves(1, 4'b0001, 100, 1'b0, 32'h0);
    @(negedge PCLK);
    compared++;
    if ({PSEL, PENABLE, ready} !== {4'b0001, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL abort pre-reset: got psel=%b en=%b rdy=%b want psel=0001 en=1 rdy=0", PSEL, PENABLE, ready);
    end
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      PREADY = '1; PSLVERR = '0;
      @(negedge PCLK);
      compared++;
      if ({PSEL, PENABLE, ready, error, rdata, PADDR, PWRITE, PWDATA} !== '0) begin
        mismatched++;
        $display("[TB] FAIL abort post-reset%0d: got psel=%b en=%b rdy=%b err=%b rd=%h pa=%h pw=%b wd=%h want all 0",
                 c, PSEL, PENABLE, ready, error, rdata, PADDR, PWRITE, PWDATA);
      end
      @(posedge PCLK); #1;
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [31:0] ra [N];
    logic        rw [N];
    logic [31:0] rwd[N];
    logic [31:0] rrd[N];
    int          rws[N];
    logic        rse[N];
    bit          rkp[N];
    int          r;
    for (int i = 0; i < N; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       ra[i] = BASE + 32'($urandom_range(0, NS - 1)) * 32'd4096 + ($urandom & 32'hFFC);
      else if (r == 7) ra[i] = $urandom & 32'h0FFF_FFFC;
      else if (r == 8) ra[i] = BASE + 32'(NS) * 32'd4096 + ($urandom & 32'hF_FFFC);
      else             ra[i] = 32'hF000_0000 | $urandom;
      rw[i]  = 1'($urandom);
      rwd[i] = $urandom;
      rrd[i] = $urandom;
      rws[i] = $urandom_range(0, 10);
      rse[i] = ($urandom_range(0, 3) == 0);
      rkp[i] = (i < N - 1) && ($urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < N; i++) begin
      if (i == 0 || !rkp[i-1]) issue(ra[i], rw[i], rwd[i]);
      if (rkp[i])
        run_txn("random_b2b", ra[i], rw[i], rwd[i], rws[i], rse[i], rrd[i], 1, ra[i+1], rw[i+1], rwd[i+1]);
      else
        run_txn("random", ra[i], rw[i], rwd[i], rws[i], rse[i], rrd[i], 0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_decode_error();
    test_timeout();
    test_slverr();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
